rv32i_encoder: RTL and testbench

Streaming RV32I instruction encoder: the inverse of the core's `control` decode path. It accepts decoded micro-op fields (instruction class, ALU op in the core's ALU encoding, register indices, immediate) over a valid/ready handshake and emits canonical 32-bit RV32I instruction words. The output side is buffered in a 2-entry FIFO. It feeds the instruction-memory loader and the self-check harness that drives `control` with generated programs.

---
 rtl/rv32i_encoder.sv | 198 +++++++++++++++++++
 tb/tb_rv32i_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_encoder
// Brief    : Streaming RV32I encoder from decoded micro-op fields to 32-bit
//            instruction words. It validates each request and buffers the
//            encoded words in a 2-entry output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_encoder (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    output logic        o_rdy,
    input  logic [3:0]  i_cls,
    input  logic [3:0]  i_alu_op,
    input  logic [2:0]  i_br_f3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_emit_cnt,
    output logic [7:0]  o_err_cnt
);

    localparam logic [3:0] c_CLS_R      = 4'd0;
    localparam logic [3:0] c_CLS_I      = 4'd1;
    localparam logic [3:0] c_CLS_LOAD   = 4'd2;
    localparam logic [3:0] c_CLS_STORE  = 4'd3;
    localparam logic [3:0] c_CLS_BRANCH = 4'd4;
    localparam logic [3:0] c_CLS_JAL    = 4'd5;
    localparam logic [3:0] c_CLS_JALR   = 4'd6;
    localparam logic [3:0] c_CLS_LUI    = 4'd7;
    localparam logic [3:0] c_CLS_AUIPC  = 4'd8;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_RANGE   = 2'b10;
    localparam logic [1:0] c_ERR_ALIGN   = 2'b11;

    localparam logic [6:0] c_F7_ALT = 7'b0100000;

    logic        [2:0]  w_f3;
    logic        [6:0]  w_f7;
    logic               w_alu_bad;
    logic               w_is_shift;
    logic               w_is_sub;
    logic signed [31:0] w_imm_s;
    logic               w_in_12;
    logic               w_in_br;
    logic               w_in_jal;
    logic        [31:0] w_word;
    logic        [1:0]  w_err;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    logic [31:0] r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_emit_cnt;
    logic [7:0]  r_err_cnt;

    assign w_imm_s  = $signed(i_imm);
    assign w_in_12  = (w_imm_s >= -32'sd2048)    && (w_imm_s <= 32'sd2047);
    assign w_in_br  = (w_imm_s >= -32'sd4096)    && (w_imm_s <= 32'sd4094);
    assign w_in_jal = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574);

    assign w_is_shift = (i_alu_op == 4'b0101) || (i_alu_op == 4'b0110) || (i_alu_op == 4'b0111);
    assign w_is_sub   = (i_alu_op == 4'b0001);

    // ALU op to funct3/funct7; the same mapping serves R and I-ALU forms
    always_comb begin
        w_f3      = 3'b000;
        w_f7      = 7'b0000000;
        w_alu_bad = 1'b0;
        case (i_alu_op)
            4'b0000: w_f3 = 3'b000;
            4'b0001: begin w_f3 = 3'b000; w_f7 = c_F7_ALT; end
            4'b0010: w_f3 = 3'b111;
            4'b0011: w_f3 = 3'b110;
            4'b0100: w_f3 = 3'b100;
            4'b0101: w_f3 = 3'b001;
            4'b0110: w_f3 = 3'b101;
            4'b0111: begin w_f3 = 3'b101; w_f7 = c_F7_ALT; end
            4'b1000: w_f3 = 3'b010;
            4'b1001: w_f3 = 3'b011;
            default: w_alu_bad = 1'b1;
        endcase
    end

    // Check order in each branch sets the priority: illegal, misaligned, range
    always_comb begin
        w_word = 32'd0;
        w_err  = c_ERR_NONE;
        case (i_cls)
            c_CLS_R: begin
                w_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, 7'b0110011};
                if (w_alu_bad) w_err = c_ERR_ILLEGAL;
            end
            c_CLS_I: begin
                if (w_alu_bad || w_is_sub) begin
                    w_err = c_ERR_ILLEGAL;
                end else if (w_is_shift) begin
                    w_word = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, 7'b0010011};
                    if (i_imm[31:5] != 27'd0) w_err = c_ERR_RANGE;
                end else begin
                    w_word = {i_imm[11:0], i_rs1, w_f3, i_rd, 7'b0010011};
                    if (!w_in_12) w_err = c_ERR_RANGE;
                end
            end
            c_CLS_LOAD: begin
                w_word = {i_imm[11:0], i_rs1, 3'b010, i_rd, 7'b0000011};
                if (!w_in_12) w_err = c_ERR_RANGE;
            end
            c_CLS_STORE: begin
                w_word = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], 7'b0100011};
                if (!w_in_12) w_err = c_ERR_RANGE;
            end
            c_CLS_BRANCH: begin
                w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_br_f3,
                          i_imm[4:1], i_imm[11], 7'b1100011};
                if (i_br_f3 == 3'b010 || i_br_f3 == 3'b011) w_err = c_ERR_ILLEGAL;
                else if (i_imm[0])                          w_err = c_ERR_ALIGN;
                else if (!w_in_br)                          w_err = c_ERR_RANGE;
            end
            c_CLS_JAL: begin
                w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, 7'b1101111};
                if (i_imm[0])       w_err = c_ERR_ALIGN;
                else if (!w_in_jal) w_err = c_ERR_RANGE;
            end
            c_CLS_JALR: begin
                w_word = {i_imm[11:0], i_rs1, 3'b000, i_rd, 7'b1100111};
                if (!w_in_12) w_err = c_ERR_RANGE;
            end
            c_CLS_LUI: begin
                w_word = {i_imm[31:12], i_rd, 7'b0110111};
                if (i_imm[11:0] != 12'd0) w_err = c_ERR_RANGE;
            end
            c_CLS_AUIPC: begin
                w_word = {i_imm[31:12], i_rd, 7'b0010111};
                if (i_imm[11:0] != 12'd0) w_err = c_ERR_RANGE;
            end
            default: w_err = c_ERR_ILLEGAL;
        endcase
    end

    assign o_rdy    = (r_count != 2'd2);
    assign o_vld    = (r_count != 2'd0);
    assign w_accept = i_vld & o_rdy;
    assign w_push   = w_accept & (w_err == c_ERR_NONE);
    assign w_pop    = o_vld & i_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0]   <= 32'd0;
            r_mem[1]   <= 32'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_emit_cnt <= 16'd0;
            r_err_cnt  <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr   <= ~r_rd_ptr;
                r_emit_cnt <= r_emit_cnt + 16'd1;
            end
            if (w_push && !w_pop)      r_count <= r_count + 2'd1;
            else if (!w_push && w_pop) r_count <= r_count - 2'd1;

            r_err      <= w_accept && (w_err != c_ERR_NONE);
            r_err_code <= w_accept ? w_err : c_ERR_NONE;
            if (w_accept && (w_err != c_ERR_NONE) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_instr    = r_mem[r_rd_ptr];
    assign o_err      = r_err;
    assign o_err_code = r_err_code;
    assign o_emit_cnt = r_emit_cnt;
    assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_encoder
// Brief    : Table-driven directed bench for rv32i_encoder with hand-written
//            backpressure, error, saturation and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_encoder;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_vld;
    logic        w_o_rdy;
    logic [3:0]  r_cls;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_br_f3;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;
    logic [31:0] w_o_instr;
    logic        w_o_vld;
    logic        r_rdy;
    logic        w_o_err;
    logic [1:0]  w_o_err_code;
    logic [15:0] w_o_emit_cnt;
    logic [7:0]  w_o_err_cnt;

    int n_applied = 0;
    int n_miss    = 0;
    int n_good    = 0;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    always #5 r_clk = ~r_clk;

    rv32i_encoder u_dut (
        .i_clk      (r_clk),
        .i_rst      (r_rst),
        .i_vld      (r_vld),
        .o_rdy      (w_o_rdy),
        .i_cls      (r_cls),
        .i_alu_op   (r_alu_op),
        .i_br_f3    (r_br_f3),
        .i_rd       (r_rd),
        .i_rs1      (r_rs1),
        .i_rs2      (r_rs2),
        .i_imm      (r_imm),
        .o_instr    (w_o_instr),
        .o_vld      (w_o_vld),
        .i_rdy      (r_rdy),
        .o_err      (w_o_err),
        .o_err_code (w_o_err_code),
        .o_emit_cnt (w_o_emit_cnt),
        .o_err_cnt  (w_o_err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] cls, input logic [3:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic is_err, input logic [1:0] code,
                       input logic [31:0] instr);
        vec_t v;
        v = '{cls: cls, op: op, f3: f3, rd: rd, rs1: rs1, rs2: rs2, imm: imm,
              is_err: is_err, code: code, instr: instr};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        r_cls    = v.cls;
        r_alu_op = v.op;
        r_br_f3  = v.f3;
        r_rd     = v.rd;
        r_rs1    = v.rs1;
        r_rs2    = v.rs2;
        r_imm    = v.imm;
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        r_rst = 1'b1;
        r_vld = 1'b0;
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    initial begin
        r_rst = 1'b1; r_vld = 1'b0; r_rdy = 1'b1;
        r_cls = '0; r_alu_op = '0; r_br_f3 = '0; r_rd = '0; r_rs1 = '0; r_rs2 = '0; r_imm = '0;

        //   cls  op  f3 rd rs1 rs2 imm          err code instr
        add(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5,        1'b0, 2'b00, 32'h00500093); // ADDI
        add(4'd1, 4'd7, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3,        1'b0, 2'b00, 32'h40315093); // SRAI
        add(4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 2'b00, 32'h002081B3); // ADD
        add(4'd0, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 2'b00, 32'h402081B3); // SUB
        add(4'd2, 4'd0, 3'd0, 5'd5, 5'd2, 5'd0, 32'd8,        1'b0, 2'b00, 32'h00812283); // LW
        add(4'd3, 4'd0, 3'd0, 5'd0, 5'd2, 5'd5, 32'd12,       1'b0, 2'b00, 32'h00512623); // SW
        add(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 2'b00, 32'h00208463); // BEQ +8
        add(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7,        1'b1, 2'b11, 32'h0);        // BEQ odd
        add(4'd7, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 2'b00, 32'h123452B7); // LUI
        add(4'd5, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800,      1'b0, 2'b00, 32'h001000EF); // JAL +2048
        add(4'd5, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd4,      1'b0, 2'b00, 32'hFFDFF06F); // JAL -4
        add(4'd5, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b0, 2'b00, 32'h8000006F); // JAL min
        add(4'd6, 4'd0, 3'd0, 5'd1, 5'd5, 5'd0, 32'd0,        1'b0, 2'b00, 32'h000280E7); // JALR
        add(4'd8, 4'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'hFFFFF000, 1'b0, 2'b00, 32'hFFFFF197); // AUIPC
        add(4'd1, 4'd0, 3'd0, 5'd2, 5'd2, 5'd0, -32'sd1,      1'b0, 2'b00, 32'hFFF10113); // ADDI -1
        add(4'd4, 4'd0, 3'd1, 5'd0, 5'd1, 5'd2, -32'sd4,      1'b0, 2'b00, 32'hFE209EE3); // BNE -4
        add(4'd0, 4'd9, 3'd0, 5'd4, 5'd5, 5'd6, 32'd0,        1'b0, 2'b00, 32'h0062B233); // SLTU
        add(4'd0, 4'd7, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0,        1'b0, 2'b00, 32'h403150B3); // SRA
        add(4'd1, 4'd4, 3'd0, 5'd7, 5'd1, 5'd0, -32'sd2048,   1'b0, 2'b00, 32'h8000C393); // XORI min
        add(4'd1, 4'd5, 3'd0, 5'd1, 5'd1, 5'd0, 32'd31,       1'b0, 2'b00, 32'h01F09093); // SLLI 31
        add(4'd4, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4094,     1'b0, 2'b00, 32'h7E000FE3); // BEQ max
        add(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2047,     1'b0, 2'b00, 32'h7FF00093); // ADDI max
        add(4'd12, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,       1'b1, 2'b01, 32'h0);        // cls 12
        add(4'd9, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,        1'b1, 2'b01, 32'h0);        // cls 9
        add(4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b1, 2'b10, 32'h0);        // ADDI 2048
        add(4'd2, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, -32'sd2049,   1'b1, 2'b10, 32'h0);        // LW -2049
        add(4'd1, 4'd1, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1,        1'b1, 2'b01, 32'h0);        // I SUB
        add(4'd0, 4'd10, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,       1'b1, 2'b01, 32'h0);        // R op 1010
        add(4'd4, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 2'b01, 32'h0);        // BR f3 010
        add(4'd4, 4'd0, 3'd3, 5'd0, 5'd1, 5'd2, 32'd7,        1'b1, 2'b01, 32'h0);        // illegal > align
        add(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4097,     1'b1, 2'b11, 32'h0);        // align > range
        add(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096,     1'b1, 2'b10, 32'h0);        // BR 4096
        add(4'd1, 4'd5, 3'd0, 5'd1, 5'd1, 5'd0, 32'd32,       1'b1, 2'b10, 32'h0);        // SLLI 32
        add(4'd1, 4'd6, 3'd0, 5'd1, 5'd1, 5'd0, -32'sd1,      1'b1, 2'b10, 32'h0);        // SRLI -1
        add(4'd7, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b1, 2'b10, 32'h0);        // LUI low
        add(4'd5, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h100000,   1'b1, 2'b10, 32'h0);        // JAL 2^20
        add(4'd5, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3,        1'b1, 2'b11, 32'h0);        // JAL odd

        // Reset state
        @(negedge r_clk);
        @(negedge r_clk);
        r_rst = 1'b0;
        chk("reset o_vld",      32'(w_o_vld),      32'd0);
        chk("reset o_rdy",      32'(w_o_rdy),      32'd1);
        chk("reset o_instr",    w_o_instr,         32'd0);
        chk("reset o_err",      32'(w_o_err),      32'd0);
        chk("reset o_err_code", 32'(w_o_err_code), 32'd0);
        chk("reset emit_cnt",   32'(w_o_emit_cnt), 32'd0);
        chk("reset err_cnt",    32'(w_o_err_cnt),  32'd0);

        // Table: one request per cycle, consumer always ready
        foreach (vecs[i]) begin
            @(negedge r_clk);
            drive(vecs[i]);
            r_vld = 1'b1;
            @(posedge r_clk);
            #1;
            if (vecs[i].is_err) begin
                chk($sformatf("vec%0d o_err", i),      32'(w_o_err),      32'd1);
                chk($sformatf("vec%0d o_err_code", i), 32'(w_o_err_code), 32'(vecs[i].code));
                chk($sformatf("vec%0d o_vld", i),      32'(w_o_vld),      32'd0);
            end else begin
                n_good++;
                chk($sformatf("vec%0d o_vld", i),   32'(w_o_vld), 32'd1);
                chk($sformatf("vec%0d o_instr", i), w_o_instr,    vecs[i].instr);
                chk($sformatf("vec%0d o_err", i),   32'(w_o_err), 32'd0);
            end
        end
        @(negedge r_clk);
        r_vld = 1'b0;
        @(negedge r_clk);
        chk("table emit_cnt", 32'(w_o_emit_cnt), 32'(n_good));
        chk("table o_vld",    32'(w_o_vld),      32'd0);

        // Backpressure: third request must be refused while two are buffered
        do_reset();
        r_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge r_clk);
            drive(vecs[k]);
            r_vld = 1'b1;
            chk($sformatf("bp o_rdy req%0d", k), 32'(w_o_rdy), (k < 2) ? 32'd1 : 32'd0);
            @(posedge r_clk);
        end
        @(negedge r_clk);
        r_vld = 1'b0;
        chk("bp head0",       w_o_instr,    vecs[0].instr);
        @(negedge r_clk);
        chk("bp head0 held",  w_o_instr,    vecs[0].instr);
        chk("bp held o_vld",  32'(w_o_vld), 32'd1);
        r_rdy = 1'b1;
        @(posedge r_clk);
        #1;
        chk("bp head1",       w_o_instr,    vecs[1].instr);
        chk("bp o_rdy after pop", 32'(w_o_rdy), 32'd1);
        @(posedge r_clk);
        #1;
        chk("bp drained o_vld", 32'(w_o_vld),      32'd0);
        chk("bp emit_cnt",      32'(w_o_emit_cnt), 32'd2);

        // Three rejected requests back to back
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge r_clk);
            r_cls = (k == 0) ? 4'd12 : 4'd1;
            r_alu_op = (k == 2) ? 4'd1 : 4'd0;
            r_imm = (k == 1) ? 32'd2048 : 32'd0;
            r_vld = 1'b1;
            @(posedge r_clk);
            #1;
            chk($sformatf("errseq%0d o_err", k), 32'(w_o_err), 32'd1);
            chk($sformatf("errseq%0d code", k),  32'(w_o_err_code),
                (k == 1) ? 32'd2 : 32'd1);
        end
        @(negedge r_clk);
        r_vld = 1'b0;
        @(posedge r_clk);
        #1;
        chk("errseq pulse ends", 32'(w_o_err),     32'd0);
        chk("errseq err_cnt",    32'(w_o_err_cnt), 32'd3);
        chk("errseq o_vld",      32'(w_o_vld),     32'd0);

        // Error counter saturation
        @(negedge r_clk);
        r_cls = 4'd15;
        r_vld = 1'b1;
        repeat (260) @(posedge r_clk);
        @(negedge r_clk);
        r_vld = 1'b0;
        chk("err_cnt saturate", 32'(w_o_err_cnt), 32'd255);

        // Reset with two words buffered
        r_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge r_clk);
            drive(vecs[k]);
            r_vld = 1'b1;
            @(posedge r_clk);
        end
        @(negedge r_clk);
        r_vld = 1'b0;
        chk("pre-reset full o_rdy", 32'(w_o_rdy), 32'd0);
        r_rst = 1'b1;
        @(posedge r_clk);
        #1;
        chk("midreset o_vld",    32'(w_o_vld),      32'd0);
        chk("midreset o_rdy",    32'(w_o_rdy),      32'd1);
        chk("midreset emit_cnt", 32'(w_o_emit_cnt), 32'd0);
        chk("midreset err_cnt",  32'(w_o_err_cnt),  32'd0);
        chk("midreset o_instr",  w_o_instr,         32'd0);
        r_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
